// File: rtl/ddr_fifo_pkg.sv
// Shared helpers for the DDR wishbone slave async FIFO: pointer width and Gray coding.
package ddr_fifo_pkg;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Both conversions work on a zero-extended 32-bit value, so callers of any
    // width up to 32 just cast in and truncate the result back to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ddr_sync_bus.sv
// Multi-bit flop synchroniser; only safe for Gray-coded (single-bit-change) buses.
module ddr_sync_bus #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ddr_fifo_rd_status.sv
// Read-side pointer and status of the DDR async FIFO: syncs the write Gray pointer,
// keeps the read pointer and registers address, level and flags from next-state values.
module ddr_fifo_rd_status #(
    parameter int ADDR_WIDTH  = 4,
    parameter int AE_THRESH   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [ADDR_WIDTH:0]   WrGray_in,
    input  logic                  RdEn_in,
    input  logic                  Clear_in,
    output logic [ADDR_WIDTH-1:0] RdAddr_out,
    output logic [ADDR_WIDTH:0]   RdGray_out,
    output logic                  Empty_out,
    output logic                  AlmostEmpty_out,
    output logic [ADDR_WIDTH:0]   Level_out,
    output logic                  Underflow_out
);
    import ddr_fifo_pkg::*;

    localparam int PTR_W = ptr_width(ADDR_WIDTH);

    logic [PTR_W-1:0] w_wr_gray_sync;
    logic [PTR_W-1:0] w_wr_bin;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [PTR_W-1:0] w_level_next;
    logic             w_rd_ok;

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_rd_gray;
    logic [PTR_W-1:0] r_level;
    logic             r_empty;
    logic             r_almost_empty;
    logic             r_underflow;

    ddr_sync_bus #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_clr   (Clear_in),
        .i_d     (WrGray_in),
        .o_q     (w_wr_gray_sync)
    );

    assign w_wr_bin      = PTR_W'(gray2bin(32'(w_wr_gray_sync)));
    assign w_rd_ok       = RdEn_in & ~r_empty;
    assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_rd_ok);
    // Modular difference stays correct across the pointer wrap.
    assign w_level_next  = w_wr_bin - w_rd_ptr_next;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rd_ptr       <= '0;
            r_rd_gray      <= '0;
            r_level        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_underflow    <= 1'b0;
        end else if (Clear_in) begin
            r_rd_ptr       <= '0;
            r_rd_gray      <= '0;
            r_level        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_underflow    <= 1'b0;
        end else begin
            r_rd_ptr       <= w_rd_ptr_next;
            r_rd_gray      <= PTR_W'(bin2gray(32'(w_rd_ptr_next)));
            r_level        <= w_level_next;
            r_empty        <= (w_level_next == '0);
            r_almost_empty <= (w_level_next <= PTR_W'(AE_THRESH));
            r_underflow    <= RdEn_in & r_empty;
        end
    end

    assign RdAddr_out      = r_rd_ptr[ADDR_WIDTH-1:0];
    assign RdGray_out      = r_rd_gray;
    assign Level_out       = r_level;
    assign Empty_out       = r_empty;
    assign AlmostEmpty_out = r_almost_empty;
    assign Underflow_out   = r_underflow;

endmodule

// File: tb/tb_ddr_fifo_rd_status.sv
// Scoreboard bench for ddr_fifo_rd_status (ADDR_WIDTH=4, AE_THRESH=2, SYNC_STAGES=2).
module tb_ddr_fifo_rd_status;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int PMASK = (2 * DEPTH) - 1;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic [AW:0]   WrGray_in;
    logic          RdEn_in;
    logic          Clear_in;
    logic [AW-1:0] RdAddr_out;
    logic [AW:0]   RdGray_out;
    logic          Empty_out;
    logic          AlmostEmpty_out;
    logic [AW:0]   Level_out;
    logic          Underflow_out;

    ddr_fifo_rd_status #(.ADDR_WIDTH(AW), .AE_THRESH(2), .SYNC_STAGES(2)) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .WrGray_in       (WrGray_in),
        .RdEn_in         (RdEn_in),
        .Clear_in        (Clear_in),
        .RdAddr_out      (RdAddr_out),
        .RdGray_out      (RdGray_out),
        .Empty_out       (Empty_out),
        .AlmostEmpty_out (AlmostEmpty_out),
        .Level_out       (Level_out),
        .Underflow_out   (Underflow_out)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int addr;
        int gray;
        int level;
        int empty;
        int ae;
        int uf;
        int ok;
    } exp_t;

    exp_t q_exp[$];

    int n_checks   = 0;
    int n_failures = 0;
    int wc         = 0;   // writes completed by the bench's write side
    int m_rd       = 0;   // reads accepted by the model
    int m_s1       = 0;   // model sync stages (Gray)
    int m_s2       = 0;
    int m_empty    = 1;
    int prev_gray  = 0;
    int uf_seen    = 0;

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int from_gray(input int g);
        int b;
        b = 0;
        for (int i = AW; i >= 0; i--) begin
            b = b | ((((b >> (i + 1)) & 1) ^ ((g >> i) & 1)) << i);
        end
        return b;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_pending();
        exp_t e;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            check_eq("addr",  int'(RdAddr_out),      e.addr);
            check_eq("gray",  int'(RdGray_out),      e.gray);
            check_eq("level", int'(Level_out),       e.level);
            check_eq("empty", int'(Empty_out),       e.empty);
            check_eq("ae",    int'(AlmostEmpty_out), e.ae);
            check_eq("uf",    int'(Underflow_out),   e.uf);
            if (e.ok != 0)
                check_eq("gray_ham", $countones(int'(RdGray_out) ^ prev_gray), 1);
            prev_gray = int'(RdGray_out);
            if (Underflow_out) uf_seen++;
        end
    endtask

    // One cycle: compare last cycle's outcome, drive new inputs, predict this edge.
    task automatic step(input bit wr, input bit rd, input bit clr);
        exp_t e;
        int   lvl;
        @(negedge Clk);
        check_pending();
        if (clr) wc = 0;
        else if (wr && (wc - m_rd) < DEPTH) wc++;
        WrGray_in = (AW+1)'(to_gray(wc & PMASK));
        RdEn_in   = rd;
        Clear_in  = clr;
        if (clr) begin
            m_s1 = 0;
            m_s2 = 0;
            m_rd = 0;
            e = '{addr: 0, gray: 0, level: 0, empty: 1, ae: 1, uf: 0, ok: 0};
        end else begin
            e.ok  = (rd && m_empty == 0) ? 1 : 0;
            e.uf  = (rd && m_empty != 0) ? 1 : 0;
            m_rd  = m_rd + e.ok;
            lvl   = (from_gray(m_s2) - (m_rd & PMASK)) & PMASK;
            e.addr  = m_rd & (DEPTH - 1);
            e.gray  = to_gray(m_rd & PMASK);
            e.level = lvl;
            e.empty = (lvl == 0) ? 1 : 0;
            e.ae    = (lvl <= 2) ? 1 : 0;
            m_s2 = m_s1;
            m_s1 = int'(WrGray_in);
        end
        m_empty = e.empty;
        q_exp.push_back(e);
    endtask

    task automatic model_reset();
        q_exp.delete();
        wc = 0; m_rd = 0; m_s1 = 0; m_s2 = 0; m_empty = 1; prev_gray = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_addr"},  int'(RdAddr_out),      0);
        check_eq({tag, "_gray"},  int'(RdGray_out),      0);
        check_eq({tag, "_level"}, int'(Level_out),       0);
        check_eq({tag, "_empty"}, int'(Empty_out),       1);
        check_eq({tag, "_ae"},    int'(AlmostEmpty_out), 1);
        check_eq({tag, "_uf"},    int'(Underflow_out),   0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0; WrGray_in = '0; RdEn_in = 1'b0; Clear_in = 1'b0;
        repeat (2) @(negedge Clk);
        check_reset_outputs("rst");
        Rst_n = 1'b1;
        model_reset();

        // Fill: gray(1..5) one per cycle
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        check_eq("fill_level", int'(Level_out), 5);
        check_eq("fill_empty", int'(Empty_out), 0);
        check_eq("fill_ae",    int'(AlmostEmpty_out), 0);

        // Drain with two extra reads while empty
        uf_seen = 0;
        for (int i = 0; i < 7; i++) step(0, 1, 0);
        step(0, 0, 0);
        check_eq("drain_addr",  int'(RdAddr_out), 5);
        check_eq("drain_empty", int'(Empty_out), 1);
        check_eq("drain_uf",    uf_seen, 2);

        // Wrap: 40 write/read pairs carry both pointers past 31 -> 0
        for (int i = 0; i < 40; i++) step(1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0);
        step(0, 0, 0);
        check_eq("wrap_level", int'(Level_out), 0);
        check_eq("wrap_addr",  int'(RdAddr_out), 45 & (DEPTH - 1));

        // Simultaneous: synced write lands on the same edge as a read at level 3
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        check_eq("sim_pre_level", int'(Level_out), 3);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check_eq("sim_level", int'(Level_out), 3);
        check_eq("sim_empty", int'(Empty_out), 0);

        // Clear at level 8 with a read request pending
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        check_eq("clr_pre_level", int'(Level_out), 8);
        step(0, 1, 1);
        step(0, 0, 0);
        check_eq("clr_addr",  int'(RdAddr_out), 0);
        check_eq("clr_level", int'(Level_out), 0);
        check_eq("clr_empty", int'(Empty_out), 1);
        check_eq("clr_uf",    int'(Underflow_out), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);

        // Async reset mid-stream
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        @(posedge Clk);
        #2;
        Rst_n = 1'b0; WrGray_in = '0; RdEn_in = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < 2; i++) step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        check_eq("post_rst_level", int'(Level_out), 2);
        check_eq("post_rst_ae",    int'(AlmostEmpty_out), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
